// File: rtl/parking_day_controller.sv
// rtl/parking_day_controller.sv - parking-lot day sequencer: spot tracking, hourly RAM writes, rush window, readback stepping
module parking_day_controller #(
  parameter int NUM_SPOTS = 3,
  parameter int NUM_HOURS = 8
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       arrive_i,
  input  logic       depart_i,
  input  logic       hour_tick_i,
  input  logic       slow_tick_i,
  input  logic       restart_i,
  output logic [1:0] spots_left_o,
  output logic [3:0] hour_o,
  output logic       wr_en_o,
  output logic [3:0] wr_data_o,
  output logic [3:0] rd_addr_o,
  output logic       start_rush_o,
  output logic       stop_rush_o,
  output logic       rush_ended_o,
  output logic       end_game_o
);

  localparam logic [1:0] SPOTS_MAX = 2'(NUM_SPOTS);
  localparam logic [3:0] HOUR_LAST = 4'(NUM_HOURS - 1);

  typedef enum logic {ST_DAY, ST_READBACK} state_e;
  typedef enum logic [1:0] {RUSH_NONE, RUSH_ACTIVE, RUSH_DONE} rush_e;

  state_e     state_q, state_d;
  rush_e      rush_q, rush_d;
  logic [1:0] spots_q, spots_d;
  logic [3:0] hour_q, hour_d;
  logic [3:0] count_q, count_d;
  logic [3:0] wr_data_q, wr_data_d;
  logic [3:0] rd_addr_q, rd_addr_d;
  logic       wr_en_q, wr_en_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       ended_q, ended_d;
  logic       end_game_q, end_game_d;

  logic       take_arrival;
  logic [3:0] count_acc;

  // An arrival is accepted whenever a spot is free before the edge, even if a
  // departure on the same edge leaves spots_left unchanged.
  assign take_arrival = arrive_i && (spots_q != 2'd0);
  assign count_acc    = (take_arrival && (count_q != 4'hF)) ? count_q + 4'd1 : count_q;

  always_comb begin
    state_d    = state_q;
    rush_d     = rush_q;
    spots_d    = spots_q;
    hour_d     = hour_q;
    count_d    = count_q;
    wr_data_d  = wr_data_q;
    rd_addr_d  = rd_addr_q;
    wr_en_d    = 1'b0;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    ended_d    = ended_q;
    end_game_d = end_game_q;

    if (restart_i) begin
      state_d    = ST_DAY;
      rush_d     = RUSH_NONE;
      spots_d    = SPOTS_MAX;
      hour_d     = 4'd0;
      count_d    = 4'd0;
      wr_data_d  = 4'd0;
      rd_addr_d  = 4'd0;
      ended_d    = 1'b0;
      end_game_d = 1'b0;
    end else if (state_q == ST_DAY) begin
      if (take_arrival && !depart_i) begin
        spots_d = spots_q - 2'd1;
      end else if (depart_i && !arrive_i && (spots_q != SPOTS_MAX)) begin
        spots_d = spots_q + 2'd1;
      end
      count_d = count_acc;

      if ((rush_q == RUSH_NONE) && (spots_q != 2'd0) && (spots_d == 2'd0)) begin
        start_d = 1'b1;
        rush_d  = RUSH_ACTIVE;
      end else if ((rush_q == RUSH_ACTIVE) && (spots_q == 2'd0) && (spots_d != 2'd0)) begin
        stop_d  = 1'b1;
        ended_d = 1'b1;
        rush_d  = RUSH_DONE;
      end

      if (hour_tick_i) begin
        wr_en_d   = 1'b1;
        wr_data_d = count_acc;
        count_d   = 4'd0;
        hour_d    = hour_q + 4'd1;
        if (hour_q == HOUR_LAST) begin
          end_game_d = 1'b1;
          rd_addr_d  = 4'd0;
          state_d    = ST_READBACK;
        end
      end
    end else if (slow_tick_i) begin
      rd_addr_d = (rd_addr_q == HOUR_LAST) ? 4'd0 : rd_addr_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_DAY;
      rush_q     <= RUSH_NONE;
      spots_q    <= SPOTS_MAX;
      hour_q     <= 4'd0;
      count_q    <= 4'd0;
      wr_data_q  <= 4'd0;
      rd_addr_q  <= 4'd0;
      wr_en_q    <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      ended_q    <= 1'b0;
      end_game_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rush_q     <= rush_d;
      spots_q    <= spots_d;
      hour_q     <= hour_d;
      count_q    <= count_d;
      wr_data_q  <= wr_data_d;
      rd_addr_q  <= rd_addr_d;
      wr_en_q    <= wr_en_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      ended_q    <= ended_d;
      end_game_q <= end_game_d;
    end
  end

  assign spots_left_o = spots_q;
  assign hour_o       = hour_q;
  assign wr_en_o      = wr_en_q;
  assign wr_data_o    = wr_data_q;
  assign rd_addr_o    = rd_addr_q;
  assign start_rush_o = start_q;
  assign stop_rush_o  = stop_q;
  assign rush_ended_o = ended_q;
  assign end_game_o   = end_game_q;

endmodule

// File: tb/tb_parking_day_controller.sv
// tb/tb_parking_day_controller.sv - table-driven bench with output and write-stream scoreboards
module tb_parking_day_controller;

  logic       clk_i = 1'b0;
  logic       reset_ni = 1'b0;
  logic       arrive_i = 1'b0, depart_i = 1'b0, hour_tick_i = 1'b0;
  logic       slow_tick_i = 1'b0, restart_i = 1'b0;
  logic [1:0] spots_left_o;
  logic [3:0] hour_o, wr_data_o, rd_addr_o;
  logic       wr_en_o, start_rush_o, stop_rush_o, rush_ended_o, end_game_o;

  parking_day_controller #(.NUM_SPOTS(3), .NUM_HOURS(8)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .arrive_i(arrive_i), .depart_i(depart_i),
    .hour_tick_i(hour_tick_i), .slow_tick_i(slow_tick_i), .restart_i(restart_i),
    .spots_left_o(spots_left_o), .hour_o(hour_o), .wr_en_o(wr_en_o), .wr_data_o(wr_data_o),
    .rd_addr_o(rd_addr_o), .start_rush_o(start_rush_o), .stop_rush_o(stop_rush_o),
    .rush_ended_o(rush_ended_o), .end_game_o(end_game_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string      name;
    logic       arr, dep, tick, slow, rst;
    logic [1:0] sp;
    logic [3:0] hr, wd, rda;
    logic       wen, sr, pr, re, eg;
  } vec_t;

  vec_t       tbl[$];
  vec_t       expq[$];
  logic [7:0] wrq[$];
  int         total = 0;
  int         bad = 0;

  function automatic logic [18:0] pack(input logic [1:0] sp, input logic [3:0] hr, input logic wen,
                                       input logic [3:0] wd, input logic [3:0] rda,
                                       input logic sr, input logic pr, input logic re, input logic eg);
    // wr_data only matters while wr_en is high
    return {sp, hr, wen, (wen ? wd : 4'd0), rda, sr, pr, re, eg};
  endfunction

  task automatic add(input string n, input bit a, input bit d, input bit t, input bit s, input bit r,
                     input int sp, input int hr, input int wen, input int wd, input int rda,
                     input int sr, input int pr, input int re, input int eg);
    vec_t v;
    v.name = n; v.arr = a; v.dep = d; v.tick = t; v.slow = s; v.rst = r;
    v.sp = 2'(sp); v.hr = 4'(hr); v.wen = 1'(wen); v.wd = 4'(wd); v.rda = 4'(rda);
    v.sr = 1'(sr); v.pr = 1'(pr); v.re = 1'(re); v.eg = 1'(eg);
    tbl.push_back(v);
  endtask

  task automatic check(input string n, input logic [18:0] got, input logic [18:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got sp/hr/wen/wd/rda/sr/pr/re/eg=%b expected %b", n, got, exp);
    end
  endtask

  function automatic logic [18:0] dut_out();
    return pack(spots_left_o, hour_o, wr_en_o, wr_data_o, rd_addr_o,
                start_rush_o, stop_rush_o, rush_ended_o, end_game_o);
  endfunction

  // Write-stream scoreboard: the address is the pre-increment hour, i.e. hour-1 in the wr_en cycle.
  always @(negedge clk_i) begin
    if (reset_ni && wr_en_o) begin
      total++;
      if (wrq.size() == 0) begin
        bad++;
        $display("FAIL wr_stream: unexpected write addr=%0d data=%0d", hour_o - 4'd1, wr_data_o);
      end else begin
        logic [7:0] e;
        e = wrq.pop_front();
        if ({hour_o - 4'd1, wr_data_o} !== e) begin
          bad++;
          $display("FAIL wr_stream: got addr=%0d data=%0d expected addr=%0d data=%0d",
                   hour_o - 4'd1, wr_data_o, e[7:4], e[3:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Day 1: fill/overflow, simultaneous events, rush start/stop, day end, readback
    add("arr1",     1,0,0,0,0, 2,0,0,0,0, 0,0,0,0);
    add("arr2",     1,0,0,0,0, 1,0,0,0,0, 0,0,0,0);
    add("arr3_full",1,0,0,0,0, 0,0,0,0,0, 1,0,0,0);
    add("arr4_ovf", 1,0,0,0,0, 0,0,0,0,0, 0,0,0,0);
    add("tick_h0",  0,0,1,0,0, 0,1,1,3,0, 0,0,0,0);
    add("ad_full",  1,1,0,0,0, 0,1,0,0,0, 0,0,0,0);
    add("dep_stop", 0,1,0,0,0, 1,1,0,0,0, 0,1,1,0);
    add("dep2",     0,1,0,0,0, 2,1,0,0,0, 0,0,1,0);
    add("ad_two",   1,1,0,0,0, 2,1,0,0,0, 0,0,1,0);
    add("arr_a",    1,0,0,0,0, 1,1,0,0,0, 0,0,1,0);
    add("refill",   1,0,0,0,0, 0,1,0,0,0, 0,0,1,0);
    add("tick_h1",  0,0,1,0,0, 0,2,1,3,0, 0,0,1,0);
    add("dep_tick", 0,1,1,0,0, 1,3,1,0,0, 0,0,1,0);
    add("arr_tick", 1,0,1,0,0, 0,4,1,1,0, 0,0,1,0);
    for (int h = 4; h < 7; h++) add("tick_mid", 0,0,1,0,0, 0,h+1,1,0,0, 0,0,1,0);
    add("tick_last",0,0,1,0,0, 0,8,1,0,0, 0,0,1,1);
    add("rb_ignore",1,0,1,0,0, 0,8,0,0,0, 0,0,1,1);
    add("rb_dep",   0,1,0,0,0, 0,8,0,0,0, 0,0,1,1);
    for (int i = 1; i <= 9; i++) add("slow", 0,0,0,1,0, 0,8,0,0,i%8, 0,0,1,1);
    add("restart",  0,0,0,0,1, 3,0,0,0,0, 0,0,0,0);
    // Day 2: rush window fills in hour 3, ends in hour 4, no second start in hour 5
    for (int h = 0; h < 3; h++) add("b_tick", 0,0,1,0,0, 3,h+1,1,0,0, 0,0,0,0);
    add("b_arr1",   1,0,0,0,0, 2,3,0,0,0, 0,0,0,0);
    add("b_arr2",   1,0,0,0,0, 1,3,0,0,0, 0,0,0,0);
    add("b_full_h3",1,0,0,0,0, 0,3,0,0,0, 1,0,0,0);
    add("b_tick_h3",0,0,1,0,0, 0,4,1,3,0, 0,0,0,0);
    add("b_stop_h4",0,1,0,0,0, 1,4,0,0,0, 0,1,1,0);
    add("b_tick_h4",0,0,1,0,0, 1,5,1,0,0, 0,0,1,0);
    add("b_refill", 1,0,0,0,0, 0,5,0,0,0, 0,0,1,0);
    add("b_tick_h5",0,0,1,0,0, 0,6,1,1,0, 0,0,1,0);
    add("b_tick_h6",0,0,1,0,0, 0,7,1,0,0, 0,0,1,0);
    add("b_tick_h7",0,0,1,0,0, 0,8,1,0,0, 0,0,1,1);
    add("rst_prio", 1,0,1,0,1, 3,0,0,0,0, 0,0,0,0);
    // Day 3: rush still active at day end
    add("c_arr1",   1,0,0,0,0, 2,0,0,0,0, 0,0,0,0);
    add("c_arr2",   1,0,0,0,0, 1,0,0,0,0, 0,0,0,0);
    add("c_full",   1,0,0,0,0, 0,0,0,0,0, 1,0,0,0);
    add("c_tick_h0",0,0,1,0,0, 0,1,1,3,0, 0,0,0,0);
    for (int h = 1; h < 7; h++) add("c_tick", 0,0,1,0,0, 0,h+1,1,0,0, 0,0,0,0);
    add("c_tick_h7",0,0,1,0,0, 0,8,1,0,0, 0,0,0,1);
    add("c_restart",0,0,0,0,1, 3,0,0,0,0, 0,0,0,0);

    repeat (3) @(negedge clk_i);
    check("reset_state", dut_out(), pack(2'd3, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    reset_ni = 1'b1;

    foreach (tbl[k]) begin
      vec_t v, e;
      v = tbl[k];
      arrive_i = v.arr; depart_i = v.dep; hour_tick_i = v.tick;
      slow_tick_i = v.slow; restart_i = v.rst;
      expq.push_back(v);
      if (v.wen) wrq.push_back({v.hr - 4'd1, v.wd});
      @(negedge clk_i);
      arrive_i = 1'b0; depart_i = 1'b0; hour_tick_i = 1'b0; slow_tick_i = 1'b0; restart_i = 1'b0;
      e = expq.pop_front();
      check(e.name, dut_out(), pack(e.sp, e.hr, e.wen, e.wd, e.rda, e.sr, e.pr, e.re, e.eg));
    end

    // Asynchronous reset mid-day: outputs clear before the next clock edge
    hour_tick_i = 1'b1; arrive_i = 1'b1;
    wrq.push_back({4'd0, 4'd1});
    @(negedge clk_i);
    hour_tick_i = 1'b0;
    @(negedge clk_i);
    arrive_i = 1'b0;
    check("pre_async", dut_out(), pack(2'd1, 4'd1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    #2 reset_ni = 1'b0;
    #1 check("async_reset", dut_out(), pack(2'd3, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    #1 reset_ni = 1'b1;
    @(negedge clk_i);
    check("post_async", dut_out(), pack(2'd3, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));

    total++;
    if (wrq.size() != 0) begin
      bad++;
      $display("FAIL wr_drain: %0d expected writes never seen, expected 0", wrq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
